// File: rtl/divide_ratio_detector.sv
// divide_ratio_detector: measures period/high time of a slow synchronous signal, reports ratio and lock
module divide_ratio_detector #(
    parameter int CNT_W      = 8,
    parameter int LOCK_COUNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             locked,
    output logic             err
);
    typedef enum logic [1:0] {IDLE, MEASURE, TRACK} state_t;
    localparam logic [CNT_W-1:0] TMO = {{(CNT_W-1){1'b1}}, 1'b0};
    state_t state, state_nx;
    logic s_d, armed, rise, tmo, same;
    logic [CNT_W-1:0] cnt, hcnt, cnt_inc;
    logic [3:0] mcnt;
    // armed blocks a false rise when sig_in is already high as reset releases
    assign rise    = sig_in & ~s_d & armed;
    assign cnt_inc = cnt + CNT_W'(1);
    assign tmo     = (state != IDLE) && (cnt == TMO) && !rise;
    assign same    = cnt_inc == period;
    assign locked  = mcnt == 4'(LOCK_COUNT);
    always_comb begin
        state_nx = state;
        if (tmo)
            state_nx = IDLE;
        else if (rise)
            state_nx = (state == IDLE) ? MEASURE : TRACK;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            s_d       <= 1'b0;
            armed     <= 1'b0;
            cnt       <= '0;
            hcnt      <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            err       <= 1'b0;
            mcnt      <= '0;
        end else begin
            state <= state_nx;
            s_d   <= sig_in;
            armed <= armed | ~sig_in;
            cnt   <= rise ? '0 : cnt_inc;
            hcnt  <= rise ? CNT_W'(1) : hcnt + CNT_W'(sig_in);
            valid <= rise && (state != IDLE);
            err   <= err | tmo;
            if (rise && state != IDLE) begin
                period    <= cnt_inc;
                high_time <= hcnt;
            end
            if (tmo)
                mcnt <= '0;
            else if (rise && state == MEASURE)
                mcnt <= 4'd1;
            else if (rise && state == TRACK)
                mcnt <= !same ? 4'd1 : locked ? mcnt : mcnt + 4'd1;
        end
    end
endmodule

// File: tb/tb_divide_ratio_detector.sv
// tb_divide_ratio_detector: scoreboard bench driving scripted divided-clock patterns
module tb_divide_ratio_detector;
    localparam int LOCK = 4;
    logic clk = 0, rst = 1, sig_in = 0;
    logic [7:0] period, high_time;
    logic valid, locked, err;
    int checks = 0, failures = 0;
    logic [16:0] sb[$];
    int ph = 0, m = 0, lp = 0, cur_n = 0, cur_h = 0;

    divide_ratio_detector dut (
        .clk(clk), .rst(rst), .sig_in(sig_in), .period(period),
        .high_time(high_time), .valid(valid), .locked(locked), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit v);
        sig_in = v;
        @(posedge clk);
        #1;
    endtask

    // a rise at the start of each period closes the previous one
    task automatic run_period(input int n, input int h);
        if (ph != 0) begin
            if (ph == 1) m = 1;
            else m = (cur_n == lp) ? ((m == LOCK) ? m : m + 1) : 1;
            sb.push_back({8'(cur_n), 8'(cur_h), m == LOCK});
            lp = cur_n;
        end
        ph = (ph == 0) ? 1 : 2;
        cur_n = n;
        cur_h = h;
        for (int i = 0; i < n; i++) drive(i < h);
    endtask

    task automatic do_reset(input bit v);
        rst = 1;
        drive(v);
        rst = 0;
        ph = 0;
        m = 0;
    endtask

    always @(negedge clk) begin : monitor
        logic [16:0] e;
        if (valid) begin
            if (sb.size() == 0) chk("unexpected_valid", 1, 0);
            else begin
                e = sb.pop_front();
                chk("period", period, e[16:9]);
                chk("high_time", high_time, e[8:1]);
                chk("locked_at_valid", locked, e[0]);
            end
        end
    end

    initial begin
        do_reset(0);
        chk("rst_period", period, 0);
        chk("rst_high_time", high_time, 0);
        chk("rst_valid", valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_err", err, 0);
        drive(0);
        for (int i = 0; i < 6; i++) run_period(3, 1);
        chk("div3_locked", locked, 1);
        for (int i = 0; i < 5; i++) run_period(3, 2);
        for (int i = 0; i < 3; i++) run_period(3, 1);
        chk("hi_change_locked", locked, 1);
        for (int i = 0; i < 6; i++) run_period(2, 1);
        for (int i = 0; i < 5; i++) run_period(5, 2);
        run_period(2, 1);
        for (int i = 0; i < 6; i++) run_period(3, 1);
        for (int i = 0; i < 252; i++) drive(0);
        chk("pre_tmo_err", err, 0);
        chk("pre_tmo_locked", locked, 1);
        drive(0);
        chk("tmo_err", err, 1);
        chk("tmo_locked", locked, 0);
        chk("tmo_hold_period", period, 3);
        chk("tmo_hold_high", high_time, 1);
        ph = 0;
        m = 0;
        for (int i = 0; i < 6; i++) run_period(3, 1);
        chk("err_sticky", err, 1);
        chk("relock_after_tmo", locked, 1);
        for (int i = 0; i < 5; i++) run_period(4, 2);
        do_reset(0);
        chk("mid_rst_period", period, 0);
        chk("mid_rst_high", high_time, 0);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_locked", locked, 0);
        chk("mid_rst_err", err, 0);
        drive(0);
        for (int i = 0; i < 3; i++) run_period(4, 2);
        do_reset(1);
        for (int i = 0; i < 3; i++) drive(1);
        drive(0);
        for (int i = 0; i < 3; i++) run_period(4, 1);
        chk("high_release_period", period, 4);
        do_reset(0);
        drive(0);
        run_period(255, 1);
        run_period(3, 1);
        chk("coincident_err", err, 0);
        chk("coincident_period", period, 255);
        drive(0);
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/divide_ratio_detector.md
DIVIDE_RATIO_DETECTOR -- requirements
Module: divide_ratio_detector

Receive-side checker for divided-clock outputs: measures the period and high time of a slow signal synchronous to clk, reports the divide ratio, and declares lock.

Interface
REQ-001 Parameter CNT_W, default 8: width of the period and high-time counters and outputs.
REQ-002 Parameter LOCK_COUNT, default 4: number of consecutive identical period measurements required for lock (legal range 2..15).
REQ-003 clk  input  1  single clock; all logic is on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 sig_in  input  1  divided signal under test, synchronous to clk.
REQ-006 period  output  CNT_W  last measured period, in clk cycles between sig_in rising edges.
REQ-007 high_time  output  CNT_W  last measured count of cycles with sig_in=1 within that period.
REQ-008 valid  output  1  one-cycle pulse marking an update of period and high_time.
REQ-009 locked  output  1  high while the period is stable for at least LOCK_COUNT measurements.
REQ-010 err  output  1  sticky timeout flag; cleared only by rst.

Function
REQ-011 sig_in is registered every edge into s_d; a rise is an edge that samples sig_in=1 with s_d=0.
REQ-012 State machine: IDLE (wait for first rise), MEASURE (first period in progress), TRACK (periods being compared).
REQ-013 Counting: cnt clears to 0 at each rise and increments on every other edge; hcnt loads 1 at each rise and increments on non-rise edges that sample sig_in=1.
REQ-014 IDLE: on a rise, go to MEASURE and clear cnt; no output update.
REQ-015 MEASURE/TRACK: on a rise, load period<=cnt+1 and high_time<=hcnt, and pulse valid high for exactly the cycle after that edge.
REQ-016 MEASURE goes to TRACK at its first rise, which is measurement 1, and sets match count to 1.
REQ-017 TRACK rise with new period equal to the held period: match count increments and saturates at LOCK_COUNT.
REQ-018 locked asserts at the edge where match count reaches LOCK_COUNT.
REQ-019 TRACK rise with a different period: match count becomes 1, locked deasserts at that same edge, and the new values load.
REQ-020 A high-time change alone, with period unchanged, does not affect lock.
REQ-021 Timeout: if cnt reaches 2^CNT_W-2 with no rise, the next edge sets err=1, clears locked and match count, and forces IDLE.
REQ-022 After a timeout, period and high_time hold their values; measurement restarts at the next rise.
REQ-023 A rise and a timeout on the same edge: the rise wins and no err is set.
REQ-024 No division or multiplication is used; all comparisons are CNT_W-bit equality.

Reset
REQ-025 When rst=1 at an edge, the following take effect that edge: period=0, high_time=0, valid=0, locked=0, err=0, state=IDLE, cnt=0, hcnt=0, match count=0, s_d=0.
REQ-026 rst has priority over every other event, including a rise on the same edge.
REQ-027 Reset mid-TRACK discards the partial measurement; the first rise after reset re-enters MEASURE.
REQ-028 If sig_in=1 while rst is released, no rise is detected until sig_in returns to 0 and rises again.

Verification
REQ-029 Divide-by-3 input, high 1 of 3 cycles: valid pulses every 3 cycles, period=3, high_time=1, locked asserts on the 4th valid.
REQ-030 Divide-by-3 input, high 2 of 3 cycles: period=3, high_time=2; switching to high 1 of 3 while locked changes high_time to 1 and locked stays 1.
REQ-031 Divide-by-2 while locked, then switch to divide-by-5: at the first period=5 valid, locked drops the same cycle; locked re-asserts 3 measurements later.
REQ-032 sig_in held 0 after lock, CNT_W=8: err=1 and locked=0 at the 255th edge after the last rise; err stays set through later divide-by-3 traffic until rst.
REQ-033 rst pulsed for 1 cycle mid-TRACK (divide-by-4): all outputs are 0 after that edge; the first valid comes 2 rises after reset with period=4.
REQ-034 Rise coincident with the timeout edge (period 255, CNT_W=8): valid pulses with period=255, and err stays 0.
